btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_CH, default 5: number of independent button channels, 1..16.
REQ-002 Parameter DB_CYCLES, default 16: consecutive stable clk cycles required to accept a level change, 2..2^16.
REQ-003 Parameter LONG_CYCLES, default 1000: held cycles after accepted press before long-press event, greater than DB_CYCLES.
REQ-004 Parameter REPEAT_CYCLES, default 250: auto-repeat period in cycles after long press, 2 or more.
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 pb_in  input  N_CH  raw asynchronous active-high push-button levels.
REQ-008 repeat_en  input  N_CH  per-channel auto-repeat enable, sampled each cycle.
REQ-009 level  output  N_CH  debounced button level.
REQ-010 press  output  N_CH  one-cycle pulse on accepted press.
REQ-011 release  output  N_CH  one-cycle pulse on accepted release.
REQ-012 long_press  output  N_CH  one-cycle pulse when hold reaches LONG_CYCLES.
REQ-013 repeat  output  N_CH  one-cycle pulse every REPEAT_CYCLES after long_press while held and repeat_en set.

Function
REQ-014 Each pb_in bit SHALL pass a 2-flop synchroniser; channels are fully independent.
REQ-015 Debounce counter SHALL increment each cycle sync_out differs from level and clear on any cycle they match.
REQ-016 When the counter equals DB_CYCLES-1 with mismatch still present, level SHALL toggle on that edge and the counter SHALL clear.
REQ-017 Latency from a clean pb_in edge to level change SHALL be exactly 2+DB_CYCLES cycles.
REQ-018 press/release SHALL be registered, asserted in the same cycle level first shows the new value, for exactly one cycle.
REQ-019 Per-channel FSM states SHALL be IDLE, DOWN, LONG, REPEAT; encoding 2 bits.
REQ-020 IDLE->DOWN on level rise, hold counter cleared to 0.
REQ-021 DOWN: hold counter increments each cycle; on reaching LONG_CYCLES-1 emit long_press next edge; go LONG if repeat_en=0, else REPEAT with period counter cleared.
REQ-022 LONG: no further pulses; move to REPEAT with period counter cleared if repeat_en becomes 1.
REQ-023 REPEAT: period counter increments, emits repeat and wraps to 0 at REPEAT_CYCLES-1; return to LONG if repeat_en drops, no pulse that cycle.
REQ-024 Any state -> IDLE on level fall, counters cleared; a long_press or repeat due in that cycle SHALL be suppressed, release wins.
REQ-025 Hold and period counters SHALL be $clog2-sized to their limits and never wrap past them.
REQ-026 Bounces shorter than DB_CYCLES SHALL produce no output activity.
REQ-027 At most one of press, release, long_press, repeat SHALL be high per channel per cycle.

Reset
REQ-028 On rst=1 at an edge, synchronisers, counters, level, all pulse outputs SHALL be 0 and FSMs IDLE next cycle.
REQ-029 Reset mid-hold SHALL abort without release pulse; a button still held after reset SHALL yield press 2+DB_CYCLES cycles after rst drops.

Structure
REQ-030 Shared package btn_pkg SHALL hold FSM state constants and default parameter values.
REQ-031 Sub-module btn_channel (sync, debounce, FSM, counters for one bit) SHALL be instantiated N_CH times by generate; top holds no logic.

Verification (N_CH=5, DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8)
REQ-032 pb_in[0] 0->1 at cycle 10, held -> level[0]=1 and press[0] pulse at cycle 16; no other channel active.
REQ-033 pb_in[1] toggles every 2 cycles for 40 cycles then 0 -> level[1], press[1] stay 0 throughout.
REQ-034 pb_in[2] held 60 cycles, repeat_en[2]=1 -> long_press 20 cycles after press, repeat at +8, +16, +24..., release 6 cycles after pb_in falls.
REQ-035 pb_in[3] held, repeat_en[3]=0 until 10 cycles after long_press, then 1 -> repeat first 8 cycles after enable.
REQ-036 rst pulsed 1 cycle while pb_in[4] held in REPEAT -> all outputs 0 next cycle, no release, press[4] 6 cycles after rst deasserts.
REQ-037 All 5 channels pressed same cycle -> identical press timing on all bits, 6 cycles later.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the button conditioner.
//   - default parameter values for btn_conditioner / btn_channel
//   - per-channel FSM state encoding (2 bits)
//   - cnt_width(): counter width able to hold 0..limit-1
package btn_pkg;

    localparam int DEF_N_CH          = 5;
    localparam int DEF_DB_CYCLES     = 16;
    localparam int DEF_LONG_CYCLES   = 1000;
    localparam int DEF_REPEAT_CYCLES = 250;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DOWN   = 2'd1,
        ST_LONG   = 2'd2,
        ST_REPEAT = 2'd3
    } btn_state_t;

    function automatic int cnt_width(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one push-button channel.
//   2-flop synchroniser, debounce counter, press/hold FSM with hold and
//   auto-repeat period counters. All outputs are registered.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   pb_in           raw asynchronous button level
//   repeat_en       auto-repeat enable, sampled every cycle
//   level           debounced level
//   press           one-cycle pulse when level rises
//   release_pulse   one-cycle pulse when level falls
//   long_press      one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse    one-cycle pulse every REPEAT_CYCLES after long_press
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | debounced level low
// ST_DOWN   | pressed, hold counter running toward long_press
// ST_LONG   | long press reached, repeat disabled, silent
// ST_REPEAT | long press reached, period counter emitting repeats
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int DW = cnt_width(DB_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam int PW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
    localparam logic [PW-1:0] PER_MAX  = PW'(REPEAT_CYCLES - 1);

    logic          sync1, sync2;
    logic [DW-1:0] db_cnt;
    logic          toggle, rise, fall;

    btn_state_t    state, state_n;
    logic [HW-1:0] hold, hold_n;
    logic [PW-1:0] period, period_n;
    logic          long_n, rpt_n;

    // Level flips on the edge where the counter has already seen
    // DB_CYCLES-1 mismatching cycles and the mismatch is still present.
    assign toggle = (sync2 != level) && (db_cnt == DB_MAX);
    assign rise   = toggle & ~level;
    assign fall   = toggle & level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            db_cnt        <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            state         <= ST_IDLE;
            hold          <= '0;
            period        <= '0;
        end else begin
            sync1 <= pb_in;
            sync2 <= sync1;
            if (toggle) begin
                level  <= ~level;
                db_cnt <= '0;
            end else if (sync2 != level) begin
                db_cnt <= db_cnt + 1'b1;
            end else begin
                db_cnt <= '0;
            end
            press         <= rise;
            release_pulse <= fall;
            long_press    <= long_n;
            repeat_pulse  <= rpt_n;
            state         <= state_n;
            hold          <= hold_n;
            period        <= period_n;
        end
    end

    always_comb begin
        state_n  = state;
        hold_n   = hold;
        period_n = period;
        long_n   = 1'b0;
        rpt_n    = 1'b0;
        if (fall) begin
            // release takes priority over any long/repeat pulse due now
            state_n  = ST_IDLE;
            hold_n   = '0;
            period_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state_n = ST_DOWN;
                        hold_n  = '0;
                    end
                end
                ST_DOWN: begin
                    if (hold == HOLD_MAX) begin
                        long_n   = 1'b1;
                        period_n = '0;
                        state_n  = repeat_en ? ST_REPEAT : ST_LONG;
                    end else begin
                        hold_n = hold + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (repeat_en) begin
                        state_n  = ST_REPEAT;
                        period_n = '0;
                    end
                end
                ST_REPEAT: begin
                    if (!repeat_en) begin
                        state_n = ST_LONG;
                    end else if (period == PER_MAX) begin
                        rpt_n    = 1'b1;
                        period_n = '0;
                    end else begin
                        period_n = period + 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_CH independent push-button conditioners.
// Ports (all N_CH wide except clk/rst):
//   clk, rst        system clock, synchronous active-high reset
//   pb_in           raw asynchronous button levels
//   repeat_en       per-channel auto-repeat enable
//   level           debounced levels
//   press           press pulses
//   release_pulse   release pulses
//   long_press      long-press pulses
//   repeat_pulse    auto-repeat pulses
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pb_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .pb_in         (pb_in[i]),
            .repeat_en     (repeat_en[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule
